seg_scan: RTL and testbench

Multiplexed seven-segment display driver for the cycle computer, directly downstream of the binary-to-BCD converter. Captures the converter's 12-bit packed BCD word (hundreds, tens, units) on a load strobe and scans the three digits onto a shared segment bus with one-hot digit enables. Updates are tear-free and take effect only at a frame boundary. Per-slot anti-ghost blanking and an optional leading-zero blanking feature are included.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_decode.sv | 27 ++
 rtl/seg_scan.sv | 99 +++++++++
 tb/tb_seg_scan.sv | 111 +++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants, slot index and packed BCD types for the
// display path. The BCD struct matches the binary-to-BCD converter's output.
package seg_pkg;

  typedef enum logic [1:0] {
    UNITS    = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } slot_e;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } bcd3_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-high {g,f,e,d,c,b,a} pattern.
// Codes 10-15 show a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Three-digit multiplexed seven-segment scanner with tear-free frame updates.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] decin,
  input  logic        load,
  output logic [6:0]  segments,
  output logic [2:0]  digit_en,
  output logic        frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TERM  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] presc_q;
  slot_e         slot_q, slot_nxt;
  bcd3_t         pend_q, shown_q;
  logic          pend_v_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    en_q, en_d;

  logic       wrap, boundary;
  logic [3:0] nib;
  logic [6:0] dec;
  logic       lzb;

  assign wrap       = (presc_q == TERM);
  assign boundary   = wrap && (slot_q == HUNDREDS);
  assign frame_tick = boundary;
  assign segments   = seg_q;
  assign digit_en   = en_q;

  always_comb begin
    nib      = shown_q.uni;
    slot_nxt = UNITS;
    case (slot_q)
      UNITS:    begin nib = shown_q.uni; slot_nxt = TENS;     end
      TENS:     begin nib = shown_q.ten; slot_nxt = HUNDREDS; end
      HUNDREDS: begin nib = shown_q.hun; slot_nxt = UNITS;    end
      default:  begin nib = shown_q.uni; slot_nxt = UNITS;    end
    endcase
  end

`ifdef SEG_LZB_EN
  assign lzb = ((slot_q == HUNDREDS) && (shown_q.hun == 4'd0)) ||
               ((slot_q == TENS) && (shown_q.hun == 4'd0) && (shown_q.ten == 4'd0));
`else
  assign lzb = 1'b0;
`endif

  seg_decode u_dec (
    .nib_i (nib),
    .seg_o (dec)
  );

  always_comb begin
    en_d  = '0;
    seg_d = '0;
    if (presc_q >= BLANK) begin
      en_d  = 3'b001 << slot_q;
      seg_d = lzb ? '0 : dec;
    end
  end

  // A load on the boundary bypasses pending; its pend_v set is overridden below.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      slot_q   <= UNITS;
      pend_q   <= '0;
      shown_q  <= '0;
      pend_v_q <= 1'b0;
      seg_q    <= '0;
      en_q     <= '0;
    end else begin
      presc_q <= wrap ? '0 : presc_q + 1'b1;
      if (wrap) slot_q <= slot_nxt;
      if (load) begin
        pend_q   <= decin;
        pend_v_q <= 1'b1;
      end
      if (boundary) begin
        if (load)          shown_q <= decin;
        else if (pend_v_q) shown_q <= pend_q;
        pend_v_q <= 1'b0;
      end
      en_q  <= en_d;
      seg_q <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with REFRESH_DIV=4, BLANK_CYCLES=1.
// Expected frame patterns switch with SEG_LZB_EN.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [11:0] decin = '0;
  logic [6:0]  segments;
  logic [2:0]  digit_en;
  logic        frame_tick;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

`ifdef SEG_LZB_EN
  localparam logic [6:0] ZB = 7'h00;
`else
  localparam logic [6:0] ZB = 7'h3F;
`endif

  seg_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .decin      (decin),
    .load       (load),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Outputs after edge n reflect state index n-1; frame_tick reflects index n.
  task automatic step(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic ld, input logic [11:0] v);
    logic [6:0] pats [3];
    int s, presc, slot;
    logic [2:0] een;
    logic [6:0] eseg;
    pats[0] = p0; pats[1] = p1; pats[2] = p2;
    load  = ld;
    decin = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    cyc++;
    s     = cyc - 1;
    presc = s % 4;
    slot  = (s / 4) % 3;
    een   = (presc < 1) ? 3'b000 : (3'b001 << slot);
    eseg  = (een == 3'b000) ? 7'h00 : pats[slot];
    chk("digit_en", {4'b0, digit_en}, {4'b0, een});
    chk("segments", segments, eseg);
    chk("frame_tick", {6'b0, frame_tick}, {6'b0, (cyc % 12) == 11});
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                       input int la, input logic [11:0] lv, input int lb, input logic [11:0] lw);
    for (int k = 0; k < 12; k++)
      step(p0, p1, p2, (k == la) || (k == lb), (k == lb) ? lw : lv);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_segments", segments, 7'h00);
    chk("rst_digit_en", {4'b0, digit_en}, 7'h00);
    chk("rst_frame_tick", {6'b0, frame_tick}, 7'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    do_reset();
    // Power-up frame shows zeros.
    frame(7'h3F, ZB, ZB, -1, 12'h000, -1, 12'h000);
    // Mid-frame load of 927 appears from the next frame.
    frame(7'h3F, ZB, ZB, 3, 12'h927, -1, 12'h000);
    frame(7'h07, 7'h5B, 7'h6F, -1, 12'h000, -1, 12'h000);
    // Two loads in a frame: only the newer one is shown.
    frame(7'h07, 7'h5B, 7'h6F, 2, 12'h111, 9, 12'h345);
    frame(7'h6D, 7'h66, 7'h4F, -1, 12'h000, -1, 12'h000);
    // Pending value superseded by a load on the boundary cycle itself.
    frame(7'h6D, 7'h66, 7'h4F, 4, 12'h888, 11, 12'h3A5);
    frame(7'h6D, 7'h40, 7'h4F, 6, 12'h007, -1, 12'h000);
    frame(7'h07, ZB, ZB, -1, 12'h000, -1, 12'h000);
    // Reset mid-frame with a pending value.
    for (int k = 0; k < 5; k++)
      step(7'h07, ZB, ZB, k == 2, 12'h555);
    do_reset();
    frame(7'h3F, ZB, ZB, -1, 12'h000, -1, 12'h000);
    frame(7'h3F, ZB, ZB, -1, 12'h000, -1, 12'h000);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
